wavepool_feeder: RTL and testbench
==================================

WAVEPOOL_FEEDER -- requirements
Module: wavepool_feeder

Interface
REQ-001 The block SHALL expose the ports listed in REQ-002 to REQ-011; one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_wf  input  40  per-wavefront slot-valid vector from the wavepool.
REQ-005 q_empty  input  40  per-wavefront instruction-queue-empty vector from the wavepool.
REQ-006 q_reset  input  40  per-wavefront flush (halt/branch-taken/recover) from the wavepool.
REQ-007 decode_ready  input  1  decode can accept an instruction this cycle.
REQ-008 issue_done  input  1  an issued instruction of issue_done_wfid has retired from decode/issue.
REQ-009 issue_done_wfid  input  6  wavefront id qualified by issue_done.
REQ-010 feed_valid  output  1  registered; one-cycle pulse per selected instruction.
REQ-011 feed_wfid  output  6  registered; wavefront id qualified by feed_valid.

Function
REQ-012 State SHALL be: rr_ptr (6 bits, range 0..39), inflight (40 bits), feed_valid register, feed_wfid register.
REQ-013 eligible[i] SHALL be valid_wf[i] & ~q_empty[i] & ~inflight[i] & ~q_reset[i], using registered inflight.
REQ-014 Selection SHALL be combinational round-robin: lowest i in circular order starting at rr_ptr, wrapping 39->0.
REQ-015 A grant SHALL occur in cycle N iff decode_ready=1, rst=0 and any eligible bit is set.
REQ-016 On a grant in cycle N: feed_valid=1 and feed_wfid=selected id in cycle N+1 (latency 1); inflight[sel] set at the same edge; rr_ptr <= sel+1, with 39+1 wrapping to 0.
REQ-017 With no grant: feed_valid=0 next cycle; feed_wfid holds its last value; rr_ptr unchanged.
REQ-018 At most one instruction per wavefront SHALL be in flight; a wavefront with inflight=1 is never selected.
REQ-019 inflight[i] SHALL clear at the edge after issue_done=1 with issue_done_wfid=i, or after q_reset[i]=1.
REQ-020 An issue_done_wfid value of 40..63 SHALL be ignored; no state changes.
REQ-021 Simultaneous events: set (grant) and clear (issue_done or q_reset) of the same bit cannot coincide, because a granted bit was already not inflight and q_reset masks eligibility. If issue_done for i arrives in cycle N, i is eligible no earlier than N+1.
REQ-022 A q_reset[i] arriving in the cycle feed_valid shows wfid i SHALL NOT retract the pulse. The wavepool discards the read; inflight[i] clears at the next edge.
REQ-023 feed_valid SHALL never be asserted for two consecutive cycles with the same feed_wfid.

Reset
REQ-024 When rst=1 at an edge: rr_ptr=0, inflight=0, feed_valid=0, feed_wfid=0; this overrides any concurrent grant or clear.
REQ-025 Reset mid-operation SHALL drop all in-flight tracking; no grant is produced in the reset cycle.
REQ-026 The first possible feed_valid SHALL be in the second cycle after rst deasserts.

Verification
REQ-027 Scenario: after reset, valid_wf=q_empty-inverse for ids 3 and 7, decode_ready=1 -> feed 3 next cycle, then 7; no further grants until issue_done.
REQ-028 Scenario: ids 0, 5 and 39 eligible, rr_ptr=6 -> order 39, 0, 5 with issue_done returned each cycle; wrap verified.
REQ-029 Scenario: decode_ready=0 for 5 cycles with eligible ids -> feed_valid=0 throughout; grant in the cycle after decode_ready=1.
REQ-030 Scenario: id 12 inflight, issue_done wfid 12 in cycle N, only id 12 eligible -> feed_valid for 12 appears in cycle N+2 at earliest.
REQ-031 Scenario: q_reset[20]=1 in the same cycle 20 would be selected -> no grant to 20; inflight[20] stays 0; next eligible id is chosen.
REQ-032 Scenario: rst asserted while inflight=0x00_0000_0F00 and feed_valid=1 -> next cycle all outputs 0 and inflight cleared; issue_done_wfid=45 -> no effect.

Source files
------------

// File: rtl/wavepool_feeder.sv
// Round-robin feeder between the wavepool and decode. It picks one eligible wavefront per cycle
// and allows at most one instruction in flight per wavefront.
module wavepool_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] valid_wf,
    input  logic [39:0] q_empty,
    input  logic [39:0] q_reset,
    input  logic        decode_ready,
    input  logic        issue_done,
    input  logic [5:0]  issue_done_wfid,
    output logic        feed_valid,
    output logic [5:0]  feed_wfid
);
    localparam int NUM_WF = 40;

    logic [5:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_WF-1:0] inflight_q, inflight_d;
    logic              feed_valid_q, feed_valid_d;
    logic [5:0]        feed_wfid_q, feed_wfid_d;

    logic [NUM_WF-1:0] eligible;
    logic [NUM_WF-1:0] done_hit;
    logic              grant;
    logic [5:0]        sel;
    logic [6:0]        cand;

    // Ids 40..63 never match any done_hit bit, so out-of-range retirements are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WF; gi++) begin : g_wf
            assign eligible[gi] = valid_wf[gi] & ~q_empty[gi] & ~inflight_q[gi] & ~q_reset[gi];
            assign done_hit[gi] = issue_done && (issue_done_wfid == 6'(gi));
        end
    endgenerate

    // The scan runs from the farthest offset down to offset 0.
    // The last hit it records is therefore the nearest eligible id at or after rr_ptr.
    always_comb begin
        grant = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = NUM_WF - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + 7'(k);
            if (cand >= 7'(NUM_WF)) begin
                cand = cand - 7'(NUM_WF);
            end
            if (eligible[cand[5:0]]) begin
                grant = 1'b1;
                sel   = cand[5:0];
            end
        end
        grant = grant & decode_ready & ~rst;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        inflight_d   = inflight_q & ~q_reset & ~done_hit;
        feed_valid_d = 1'b0;
        feed_wfid_d  = feed_wfid_q;
        if (grant) begin
            inflight_d   = inflight_d | (NUM_WF'(1) << sel);
            rr_ptr_d     = (sel == 6'(NUM_WF - 1)) ? 6'd0 : sel + 6'd1;
            feed_valid_d = 1'b1;
            feed_wfid_d  = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            inflight_q   <= '0;
            feed_valid_q <= 1'b0;
            feed_wfid_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            inflight_q   <= inflight_d;
            feed_valid_q <= feed_valid_d;
            feed_wfid_q  <= feed_wfid_d;
        end
    end

    assign feed_valid = feed_valid_q;
    assign feed_wfid  = feed_wfid_q;
endmodule

// File: tb/tb_wavepool_feeder.sv
// Self-checking bench for wavepool_feeder: directed scenarios plus randomized traffic.
// All traffic is checked against a behavioural round-robin model.
module tb_wavepool_feeder;
    logic        clk;
    logic        rst;
    logic [39:0] valid_wf;
    logic [39:0] q_empty;
    logic [39:0] q_reset;
    logic        decode_ready;
    logic        issue_done;
    logic [5:0]  issue_done_wfid;
    logic        feed_valid;
    logic [5:0]  feed_wfid;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit [39:0] m_inflight;
    int        m_rr;
    bit        exp_fv;
    int        exp_wfid;

    wavepool_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .valid_wf        (valid_wf),
        .q_empty         (q_empty),
        .q_reset         (q_reset),
        .decode_ready    (decode_ready),
        .issue_done      (issue_done),
        .issue_done_wfid (issue_done_wfid),
        .feed_valid      (feed_valid),
        .feed_wfid       (feed_wfid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle: predict the post-edge outputs from the inputs of this cycle.
    task automatic tick();
        bit g;
        int sel;
        g   = 1'b0;
        sel = 0;
        if (!rst && decode_ready) begin
            for (int k = 0; k < 40; k++) begin
                int i;
                i = (m_rr + k) % 40;
                if (valid_wf[i] && !q_empty[i] && !m_inflight[i] && !q_reset[i]) begin
                    g   = 1'b1;
                    sel = i;
                    break;
                end
            end
        end
        if (rst) begin
            m_rr       = 0;
            m_inflight = '0;
            exp_fv     = 1'b0;
            exp_wfid   = 0;
        end else begin
            for (int i = 0; i < 40; i++) begin
                if (q_reset[i]) m_inflight[i] = 1'b0;
            end
            if (issue_done && issue_done_wfid < 6'd40) m_inflight[issue_done_wfid] = 1'b0;
            exp_fv = g;
            if (g) begin
                m_inflight[sel] = 1'b1;
                m_rr            = (sel + 1) % 40;
                exp_wfid        = sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_wf        = '0;
        q_empty         = '0;
        q_reset         = '0;
        decode_ready    = 1'b0;
        issue_done      = 1'b0;
        issue_done_wfid = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        valid_wf     = '1;
        decode_ready = 1'b1;
        rst          = 1'b1;
        tick();
        checks++;
        if (feed_valid !== 1'b0 || feed_wfid !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b wfid=%0d, want valid=0 wfid=0", feed_valid, feed_wfid);
        end
        rst = 1'b0;
    endtask

    task automatic test_two_ids();
        int want[2] = '{3, 7};
        do_reset();
        valid_wf     = (40'd1 << 3) | (40'd1 << 7);
        q_empty      = ~valid_wf;
        decode_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            checks++;
            if (feed_valid !== 1'b1 || feed_wfid !== 6'(want[j])) begin
                errors++;
                $display("FAIL two_ids_feed%0d: got valid=%0b wfid=%0d, want valid=1 wfid=%0d", j, feed_valid, feed_wfid, want[j]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (feed_valid !== 1'b0) begin
                errors++;
                $display("FAIL two_ids_idle%0d: got valid=%0b wfid=%0d, want valid=0", j, feed_valid, feed_wfid);
            end
        end
    endtask

    task automatic test_wrap();
        int want[3] = '{39, 0, 5};
        do_reset();
        decode_ready = 1'b1;
        valid_wf     = 40'd1 << 5;
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd5) begin
            errors++;
            $display("FAIL wrap_setup: got valid=%0b wfid=%0d, want valid=1 wfid=5", feed_valid, feed_wfid);
        end
        valid_wf        = '0;
        issue_done      = 1'b1;
        issue_done_wfid = 6'd5;
        tick();
        issue_done = 1'b0;
        valid_wf   = (40'd1 << 0) | (40'd1 << 5) | (40'd1 << 39);
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (feed_valid !== 1'b1 || feed_wfid !== 6'(want[j])) begin
                errors++;
                $display("FAIL wrap_order%0d: got valid=%0b wfid=%0d, want valid=1 wfid=%0d", j, feed_valid, feed_wfid, want[j]);
            end
            issue_done      = 1'b1;
            issue_done_wfid = feed_wfid;
        end
        issue_done = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        valid_wf     = 40'({$urandom(), $urandom()}) | 40'd1;
        decode_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (feed_valid !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got valid=%0b, want valid=0", j, feed_valid);
            end
        end
        decode_ready = 1'b1;
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'(exp_wfid)) begin
            errors++;
            $display("FAIL backpressure_release: got valid=%0b wfid=%0d, want valid=1 wfid=%0d", feed_valid, feed_wfid, exp_wfid);
        end
    endtask

    task automatic test_issue_done_latency();
        do_reset();
        decode_ready = 1'b1;
        valid_wf     = 40'd1 << 12;
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd12) begin
            errors++;
            $display("FAIL done_first: got valid=%0b wfid=%0d, want valid=1 wfid=12", feed_valid, feed_wfid);
        end
        tick();
        tick();
        issue_done      = 1'b1;
        issue_done_wfid = 6'd12;
        tick();
        issue_done = 1'b0;
        checks++;
        if (feed_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_n_plus_1: got valid=%0b wfid=%0d, want valid=0", feed_valid, feed_wfid);
        end
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd12) begin
            errors++;
            $display("FAIL done_n_plus_2: got valid=%0b wfid=%0d, want valid=1 wfid=12", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_q_reset();
        do_reset();
        decode_ready = 1'b1;
        valid_wf     = (40'd1 << 20) | (40'd1 << 25);
        q_reset      = 40'd1 << 20;
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd25) begin
            errors++;
            $display("FAIL qreset_skip: got valid=%0b wfid=%0d, want valid=1 wfid=25", feed_valid, feed_wfid);
        end
        q_reset = '0;
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd20) begin
            errors++;
            $display("FAIL qreset_after: got valid=%0b wfid=%0d, want valid=1 wfid=20", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        decode_ready = 1'b1;
        valid_wf     = 40'h00_0000_0F00;
        for (int j = 0; j < 4; j++) tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd11) begin
            errors++;
            $display("FAIL midop_fill: got valid=%0b wfid=%0d, want valid=1 wfid=11", feed_valid, feed_wfid);
        end
        rst             = 1'b1;
        issue_done      = 1'b1;
        issue_done_wfid = 6'd45;
        tick();
        rst        = 1'b0;
        issue_done = 1'b0;
        checks++;
        if (feed_valid !== 1'b0 || feed_wfid !== 6'd0) begin
            errors++;
            $display("FAIL midop_reset: got valid=%0b wfid=%0d, want valid=0 wfid=0", feed_valid, feed_wfid);
        end
        tick();
        checks++;
        if (feed_valid !== 1'b1 || feed_wfid !== 6'd8) begin
            errors++;
            $display("FAIL midop_regrant: got valid=%0b wfid=%0d, want valid=1 wfid=8", feed_valid, feed_wfid);
        end
    endtask

    task automatic test_random();
        bit prev_fv;
        int prev_wfid;
        do_reset();
        prev_fv   = 1'b0;
        prev_wfid = 0;
        for (int n = 0; n < 400; n++) begin
            int pend[$];
            valid_wf     = 40'({$urandom(), $urandom()});
            q_empty      = 40'({$urandom(), $urandom()}) & 40'({$urandom(), $urandom()});
            q_reset      = 40'({$urandom(), $urandom()}) & 40'({$urandom(), $urandom()})
                         & 40'({$urandom(), $urandom()});
            decode_ready = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 40; i++) if (m_inflight[i]) pend.push_back(i);
            issue_done = ($urandom_range(0, 1) == 1);
            if (pend.size() > 0 && $urandom_range(0, 4) != 0)
                issue_done_wfid = 6'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                issue_done_wfid = 6'($urandom_range(0, 63));
            tick();
            checks++;
            if (feed_valid !== exp_fv || (exp_fv && feed_wfid !== 6'(exp_wfid))) begin
                errors++;
                $display("FAIL random_c%0d: got valid=%0b wfid=%0d, want valid=%0b wfid=%0d", n, feed_valid, feed_wfid, exp_fv, exp_wfid);
            end
            if (feed_valid && prev_fv) begin
                checks++;
                if (int'(feed_wfid) == prev_wfid) begin
                    errors++;
                    $display("FAIL random_repeat_c%0d: got wfid=%0d twice in a row, want distinct", n, feed_wfid);
                end
            end
            prev_fv   = feed_valid;
            prev_wfid = int'(feed_wfid);
        end
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst        = 1'b1;
        m_inflight = '0;
        m_rr       = 0;
        exp_fv     = 1'b0;
        exp_wfid   = 0;
        test_reset();
        test_two_ids();
        test_wrap();
        test_backpressure();
        test_issue_done_latency();
        test_q_reset();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
